hdmi_period_scheduler: RTL and testbench
========================================

// Module: hdmi_period_scheduler
// PURPOSE
//  Sequences the TMDS encoders. Generates 640x480@60 timing and decides, per pixel, the HDMI period:
//  control, video preamble/guard/video, or data-island preamble/guard/packet data.
//  Grants blanking slots to an upstream packet source through a req/ack handshake.
//  Sits between the pixel generator/packet builder and the three TMDS/TERC4 encoders, in the 25 MHz pixel domain.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48 -- horizontal timing in pixels; H_TOTAL = sum = 800
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33 -- vertical timing in lines; V_TOTAL = 525
//  CNT_W    10  -- counter width; must satisfy 2**CNT_W > max(H_TOTAL, V_TOTAL)
//  DI_OFFSET 4  -- island start offset after active video; DI_START = H_ACTIVE + DI_OFFSET
//  MAX_PKTS  2  -- maximum packets per island (per line)
//  Elaboration error unless DI_START + 12 + 32*MAX_PKTS + 12 <= H_TOTAL - 10.
// PORTS
//  clk          in   1      pixel clock (25 MHz)
//  rst_n        in   1      asynchronous reset, active low
//  enable       in   1      run; low = synchronous clear of counters and scheduler
//  pkt_req      in   1      packet source has a 32-pixel packet ready
//  pkt_ack      out  1      1-cycle pulse on the first data pixel of each granted packet
//  pkt_active   out  1      high during DI_DATA pixels
//  pkt_idx      out  5      pixel index 0..31 within the current packet
//  counter_x    out  CNT_W  pixel x of the current output pixel
//  counter_y    out  CNT_W  line y of the current output pixel
//  hsync        out  1      active-high, x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//  vsync        out  1      active-high, y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//  video_de     out  1      period == VIDEO
//  period       out  3      0 CTRL, 1 VID_PRE, 2 VID_GUARD, 3 VIDEO, 4 DI_PRE, 5 DI_GUARD, 6 DI_DATA
//  ctl          out  4      {CTL3..CTL0}: 4'b0001 in VID_PRE, 4'b0101 in DI_PRE, else 0
//  frame_start  out  1      1-cycle pulse on pixel (0,0)
// BEHAVIOUR
//  - Reset (rst_n=0, async) or enable=0 (sync): every output is 0 (period=CTRL). Internal x,y=0, island FSM IDLE.
//  - Internal x counts 0..H_TOTAL-1 and wraps; y increments on x wrap, over 0..V_TOTAL-1, and wraps.
//  - All outputs are registered: 1 clk latency from the internal counters, all mutually aligned.
//    After enable rises, the first output pixel (0,0) appears 1 clk later.
//  - VIDEO: x<H_ACTIVE && y<V_ACTIVE.
//  - Video preamble/guard apply only when the next line is active (y+1<V_ACTIVE, or y==V_TOTAL-1):
//    VID_PRE for x in H_TOTAL-10..H_TOTAL-3; VID_GUARD for x in H_TOTAL-2..H_TOTAL-1.
//  - Island FSM: IDLE, PRE, LGUARD, DATA, TGUARD.
//    IDLE->PRE only at x==DI_START with pkt_req=1; allowed on any line, including vblank.
//    PRE lasts 8 pixels, LGUARD 2 pixels. DATA lasts 32 pixels per packet; pkt_ack fires at pkt_idx==0.
//    At pkt_idx==31: if pkt_req && pkts_sent<MAX_PKTS, chain into the next DATA packet (idx wraps to 0).
//    Otherwise go to TGUARD (2 pixels, period=DI_GUARD), then IDLE.
//  - pkt_req seen outside x==DI_START is ignored until the next line's DI_START.
//    pkt_req dropping mid-packet does not truncate the packet.
//    The source holds pkt_req until ack and must present pixel data indexed by pkt_idx.
//  - pkts_sent clears in IDLE. Counters are wide enough that islands never overlap the video preamble.
//  - hsync/vsync are continuous through all periods; the TERC4 encoder embeds them.
//  - enable falling mid-island: abort. Next output is CTRL, pkt_active=0, no further ack.
//    The packet source must discard the partial packet.
// STRUCTURE
//  - hdmi_pkg: period codes, CTL_VID_PRE/CTL_DI_PRE constants, PREAMBLE_LEN=8, GUARD_LEN=2, PKT_LEN=32.
//  - Sub-module video_timing_counter: x/y counters, hsync/vsync, active flags, next-line-active.
//  - Top level: island FSM, period mux, output registers.
// TESTING
//  1. enable=1, pkt_req=0, 2 frames: VIDEO 640 px/line on y 0..479; VID_PRE x790..797, GUARD 798..799
//     on y 524 and 0..478, none on 479..523; hsync x656..751; vsync y490..491; frame_start once per 420000 clk.
//  2. pkt_req held 1: each line DI_PRE x644..651 with ctl=0101; DI_GUARD 652..653; DATA 654..717;
//     pkt_ack at 654 and 686; pkt_idx 0..31 twice; DI_GUARD 718..719; CTRL 720..789.
//  3. pkt_req held until ack, then dropped: one packet, DATA 654..685, TGUARD 686..687, 1 ack.
//  4. pkt_req rises at x=645: nothing on that line; island starts at x=644 of the next line.
//  5. enable falls at x=660 (mid-DATA): next output period=CTRL, pkt_active=0, counters 0, no more acks;
//     re-enable restarts at (0,0).
//  6. rst_n pulsed low mid-line (async, between clk edges): all outputs 0 immediately; clean frame after release.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared encodings for the HDMI period scheduler: period codes, preamble
// control words and the fixed lengths of the preamble, guard and packet phases.
package hdmi_pkg;

    typedef enum logic [2:0] {
        PER_CTRL      = 3'd0,
        PER_VID_PRE   = 3'd1,
        PER_VID_GUARD = 3'd2,
        PER_VIDEO     = 3'd3,
        PER_DI_PRE    = 3'd4,
        PER_DI_GUARD  = 3'd5,
        PER_DI_DATA   = 3'd6
    } period_e;

    typedef enum logic [2:0] {
        ISL_IDLE   = 3'd0,
        ISL_PRE    = 3'd1,
        ISL_LGUARD = 3'd2,
        ISL_DATA   = 3'd3,
        ISL_TGUARD = 3'd4
    } island_e;

    localparam logic [3:0] CTL_VID_PRE = 4'b0001;
    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PKT_LEN      = 32;
    localparam int PHASE_W      = 5;

    function automatic logic [3:0] ctl_for(input period_e p);
        logic [3:0] c;
        c = 4'b0000;
        if (p == PER_VID_PRE) c = CTL_VID_PRE;
        if (p == PER_DI_PRE)  c = CTL_DI_PRE;
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters for the pixel domain, with sync windows, active
// flags and the video preamble/guard windows at the end of each line.
module video_timing_counter
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             h_active,
    output logic             v_active,
    output logic             next_line_active,
    output logic             vid_pre_win,
    output logic             vid_guard_win
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VPRE_BEG = H_TOTAL - PREAMBLE_LEN - GUARD_LEN;
    localparam int VGRD_BEG = H_TOTAL - GUARD_LEN;

    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!enable) begin
            x_d = '0;
            y_d = '0;
        end else if (x_q == CNT_W'(H_TOTAL - 1)) begin
            x_d = '0;
            y_d = (y_q == CNT_W'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
        end else begin
            x_d = x_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_cnt    = x_q;
    assign y_cnt    = y_q;
    assign hsync    = (x_q >= CNT_W'(HS_BEG)) && (x_q < CNT_W'(HS_BEG + H_SYNC));
    assign vsync    = (y_q >= CNT_W'(VS_BEG)) && (y_q < CNT_W'(VS_BEG + V_SYNC));
    assign h_active = (x_q < CNT_W'(H_ACTIVE));
    assign v_active = (y_q < CNT_W'(V_ACTIVE));
    // The last blanking line precedes line 0, so it also carries a video preamble.
    assign next_line_active = (y_q < CNT_W'(V_ACTIVE - 1)) || (y_q == CNT_W'(V_TOTAL - 1));
    assign vid_pre_win   = (x_q >= CNT_W'(VPRE_BEG)) && (x_q < CNT_W'(VGRD_BEG));
    assign vid_guard_win = (x_q >= CNT_W'(VGRD_BEG));

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period selection for 640x480@60 plus data-island scheduling
// with a req/ack packet handshake; every output is registered and aligned.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ISL_IDLE   | no island; DI_PRE starts here at DI_START when pkt_req is set
//  ISL_PRE    | remaining data-island preamble pixels
//  ISL_LGUARD | leading guard band before packet data
//  ISL_DATA   | 32-pixel packet; may chain into another packet at idx 31
//  ISL_TGUARD | trailing guard band, then back to idle
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CNT_W     = 10,
    parameter int DI_OFFSET = 4,
    parameter int MAX_PKTS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pkt_req,
    output logic             pkt_ack,
    output logic             pkt_active,
    output logic [4:0]       pkt_idx,
    output logic [CNT_W-1:0] counter_x,
    output logic [CNT_W-1:0] counter_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_de,
    output logic [2:0]       period,
    output logic [3:0]       ctl,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DI_START = H_ACTIVE + DI_OFFSET;
    localparam int SENT_W   = $clog2(MAX_PKTS + 1);

    if (DI_START + 12 + PKT_LEN * MAX_PKTS + 12 > H_TOTAL - 10) begin : g_island_fit
        $error("data island does not fit before the video preamble");
    end
    if ((2 ** CNT_W) <= H_TOTAL || (2 ** CNT_W) <= V_TOTAL) begin : g_cnt_width
        $error("CNT_W too narrow for the raster");
    end

    logic [CNT_W-1:0] x_c, y_c;
    logic             hsync_c, vsync_c, h_act_c, v_act_c, nla_c, vpre_c, vgrd_c;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) u_timing (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .x_cnt            (x_c),
        .y_cnt            (y_c),
        .hsync            (hsync_c),
        .vsync            (vsync_c),
        .h_active         (h_act_c),
        .v_active         (v_act_c),
        .next_line_active (nla_c),
        .vid_pre_win      (vpre_c),
        .vid_guard_win    (vgrd_c)
    );

    island_e            isl_q, isl_d;
    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic [SENT_W-1:0]  sent_q, sent_d;
    logic               isl_on, ack_c, data_c;
    period_e            isl_per;

    // cnt_q is a down-counter: pixels left in the current phase after this one.
    always_comb begin
        isl_d   = isl_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        isl_on  = 1'b0;
        isl_per = PER_CTRL;
        ack_c   = 1'b0;
        data_c  = 1'b0;
        case (isl_q)
            ISL_IDLE: begin
                sent_d = '0;
                if (x_c == CNT_W'(DI_START) && pkt_req) begin
                    isl_on  = 1'b1;
                    isl_per = PER_DI_PRE;
                    isl_d   = ISL_PRE;
                    cnt_d   = PHASE_W'(PREAMBLE_LEN - 2);
                end
            end
            ISL_PRE: begin
                isl_on  = 1'b1;
                isl_per = PER_DI_PRE;
                if (cnt_q == '0) begin
                    isl_d = ISL_LGUARD;
                    cnt_d = PHASE_W'(GUARD_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ISL_LGUARD: begin
                isl_on  = 1'b1;
                isl_per = PER_DI_GUARD;
                if (cnt_q == '0) begin
                    isl_d = ISL_DATA;
                    cnt_d = PHASE_W'(PKT_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ISL_DATA: begin
                isl_on  = 1'b1;
                isl_per = PER_DI_DATA;
                data_c  = 1'b1;
                ack_c   = (cnt_q == PHASE_W'(PKT_LEN - 1));
                if (ack_c) sent_d = sent_q + 1'b1;
                if (cnt_q == '0) begin
                    if (pkt_req && sent_q < SENT_W'(MAX_PKTS)) begin
                        cnt_d = PHASE_W'(PKT_LEN - 1);
                    end else begin
                        isl_d = ISL_TGUARD;
                        cnt_d = PHASE_W'(GUARD_LEN - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ISL_TGUARD: begin
                isl_on  = 1'b1;
                isl_per = PER_DI_GUARD;
                if (cnt_q == '0) begin
                    isl_d = ISL_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                isl_d = ISL_IDLE;
                cnt_d = '0;
            end
        endcase
        if (!enable) begin
            isl_d  = ISL_IDLE;
            cnt_d  = '0;
            sent_d = '0;
        end
    end

    period_e per_c;

    always_comb begin
        per_c = PER_CTRL;
        if (isl_on)                      per_c = isl_per;
        else if (h_act_c && v_act_c)     per_c = PER_VIDEO;
        else if (nla_c && vpre_c)        per_c = PER_VID_PRE;
        else if (nla_c && vgrd_c)        per_c = PER_VID_GUARD;
    end

    period_e          period_q, period_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [CNT_W-1:0] counter_x_q, counter_x_d, counter_y_q, counter_y_d;
    logic [4:0]       pkt_idx_q, pkt_idx_d;
    logic             pkt_ack_q, pkt_ack_d, pkt_active_q, pkt_active_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             video_de_q, video_de_d, frame_start_q, frame_start_d;

    always_comb begin
        period_d      = PER_CTRL;
        ctl_d         = '0;
        counter_x_d   = '0;
        counter_y_d   = '0;
        pkt_idx_d     = '0;
        pkt_ack_d     = 1'b0;
        pkt_active_d  = 1'b0;
        hsync_d       = 1'b0;
        vsync_d       = 1'b0;
        video_de_d    = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            period_d      = per_c;
            ctl_d         = ctl_for(per_c);
            counter_x_d   = x_c;
            counter_y_d   = y_c;
            pkt_ack_d     = ack_c;
            pkt_active_d  = data_c;
            pkt_idx_d     = data_c ? (PHASE_W'(PKT_LEN - 1) - cnt_q) : '0;
            hsync_d       = hsync_c;
            vsync_d       = vsync_c;
            video_de_d    = (per_c == PER_VIDEO);
            frame_start_d = (x_c == '0) && (y_c == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isl_q         <= ISL_IDLE;
            cnt_q         <= '0;
            sent_q        <= '0;
            period_q      <= PER_CTRL;
            ctl_q         <= '0;
            counter_x_q   <= '0;
            counter_y_q   <= '0;
            pkt_idx_q     <= '0;
            pkt_ack_q     <= 1'b0;
            pkt_active_q  <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            video_de_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            isl_q         <= isl_d;
            cnt_q         <= cnt_d;
            sent_q        <= sent_d;
            period_q      <= period_d;
            ctl_q         <= ctl_d;
            counter_x_q   <= counter_x_d;
            counter_y_q   <= counter_y_d;
            pkt_idx_q     <= pkt_idx_d;
            pkt_ack_q     <= pkt_ack_d;
            pkt_active_q  <= pkt_active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_de_q    <= video_de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign period      = period_q;
    assign ctl         = ctl_q;
    assign counter_x   = counter_x_q;
    assign counter_y   = counter_y_q;
    assign pkt_idx     = pkt_idx_q;
    assign pkt_ack     = pkt_ack_q;
    assign pkt_active  = pkt_active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_de    = video_de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: default horizontal timing, a
// shortened 12-line frame (6 active, vsync on lines 7..8) to keep runs short.
module tb_hdmi_period_scheduler;

    localparam int VA = 6;
    localparam int VFP = 1;
    localparam int VS = 2;
    localparam int VBP = 3;
    localparam int VT = VA + VFP + VS + VBP;

    logic       clk = 1'b0;
    logic       rst_n, enable, pkt_req;
    logic       pkt_ack, pkt_active, hsync, vsync, video_de, frame_start;
    logic [4:0] pkt_idx;
    logic [9:0] counter_x, counter_y;
    logic [2:0] period;
    logic [3:0] ctl;

    hdmi_period_scheduler #(
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pkt_req(pkt_req),
        .pkt_ack(pkt_ack), .pkt_active(pkt_active), .pkt_idx(pkt_idx),
        .counter_x(counter_x), .counter_y(counter_y), .hsync(hsync),
        .vsync(vsync), .video_de(video_de), .period(period), .ctl(ctl),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] per_a [800];
    logic [3:0] ctl_a [800];
    logic [4:0] idx_a [800];
    logic       ack_a [800];
    logic       act_a [800];
    logic       fs_a  [800];
    int         line_xbad;

    int cbad, pbad, ctlbad, nvid, npre, ngrd, nhs, hsbad, nvs, vsbad, nfs, fsbad, islbad;
    int acc_p, acc_a, acc_fs, nack, zbad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return 64'({pkt_ack, pkt_active, pkt_idx, counter_x, counter_y, hsync,
                    vsync, video_de, period, ctl, frame_start});
    endfunction

    // Expected period at (x,y) with npkts packets in that line's island.
    function automatic int exp_per(input int x, input int y, input int npkts);
        int dend;
        dend = 654 + 32 * npkts;
        if (x < 640 && y < VA) return 3;
        if (y + 1 < VA || y == VT - 1) begin
            if (x >= 790 && x <= 797) return 1;
            if (x >= 798) return 2;
        end
        if (npkts > 0) begin
            if (x >= 644 && x <= 651) return 4;
            if (x == 652 || x == 653) return 5;
            if (x >= 654 && x < dend) return 6;
            if (x == dend || x == dend + 1) return 5;
        end
        return 0;
    endfunction

    function automatic logic [3:0] exp_ctl(input int p);
        if (p == 1) return 4'b0001;
        if (p == 4) return 4'b0101;
        return 4'b0000;
    endfunction

    function automatic int per_bad(input int y, input int npkts);
        int b = 0;
        for (int x = 0; x < 800; x++)
            if (per_a[x] !== 3'(exp_per(x, y, npkts))) b++;
        return b;
    endfunction

    function automatic int ctl_bad(input int y, input int npkts);
        int b = 0;
        for (int x = 0; x < 800; x++)
            if (ctl_a[x] !== exp_ctl(exp_per(x, y, npkts))) b++;
        return b;
    endfunction

    function automatic int ack_cnt();
        int n = 0;
        for (int x = 0; x < 800; x++) if (ack_a[x] === 1'b1) n++;
        return n;
    endfunction

    function automatic int act_cnt();
        int n = 0;
        for (int x = 0; x < 800; x++) if (act_a[x] === 1'b1) n++;
        return n;
    endfunction

    function automatic int fs_cnt();
        int n = 0;
        for (int x = 0; x < 800; x++) if (fs_a[x] === 1'b1) n++;
        return n;
    endfunction

    function automatic int idx_bad(input int npkts);
        int b = 0;
        for (int x = 654; x < 654 + 32 * npkts; x++)
            if (act_a[x] !== 1'b1 || idx_a[x] !== 5'((x - 654) % 32)) b++;
        return b;
    endfunction

    // Samples one output line; optionally drops pkt_req after an ack or raises it at raise_at.
    task automatic run_line(input int y, input bit drop_on_ack, input int raise_at);
        for (int x = 0; x < 800; x++) begin
            @(negedge clk);
            per_a[x] = period;
            ctl_a[x] = ctl;
            idx_a[x] = pkt_idx;
            ack_a[x] = pkt_ack;
            act_a[x] = pkt_active;
            fs_a[x]  = frame_start;
            if (counter_x !== 10'(x) || counter_y !== 10'(y)) line_xbad++;
            if (drop_on_ack && pkt_ack === 1'b1) pkt_req = 1'b0;
            if (x == raise_at) pkt_req = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        pkt_req = 1'b0;
        #12;
        chk("reset_outputs", all_out(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("disabled_outputs", all_out(), 64'd0);

        // Two frames of plain video timing.
        enable = 1'b1;
        cbad = 0; pbad = 0; ctlbad = 0; nvid = 0; npre = 0; ngrd = 0;
        nhs = 0; hsbad = 0; nvs = 0; vsbad = 0; nfs = 0; fsbad = 0; islbad = 0;
        for (int f = 0; f < 2; f++)
            for (int y = 0; y < VT; y++)
                for (int x = 0; x < 800; x++) begin
                    @(negedge clk);
                    if (counter_x !== 10'(x) || counter_y !== 10'(y)) cbad++;
                    if (period !== 3'(exp_per(x, y, 0))) pbad++;
                    if (ctl !== exp_ctl(exp_per(x, y, 0))) ctlbad++;
                    if (video_de === 1'b1) nvid++;
                    if (period === 3'd1) npre++;
                    if (period === 3'd2) ngrd++;
                    if (hsync === 1'b1) nhs++;
                    if (hsync !== (x >= 656 && x < 752)) hsbad++;
                    if (vsync === 1'b1) nvs++;
                    if (vsync !== (y >= 7 && y < 9)) vsbad++;
                    if (frame_start === 1'b1) nfs++;
                    if (frame_start !== (x == 0 && y == 0)) fsbad++;
                    if (pkt_ack !== 1'b0 || pkt_active !== 1'b0 || pkt_idx !== 5'd0) islbad++;
                end
        chk("t1_counter_errs", 64'(cbad), 64'd0);
        chk("t1_period_errs", 64'(pbad), 64'd0);
        chk("t1_ctl_errs", 64'(ctlbad), 64'd0);
        chk("t1_video_px", 64'(nvid), 64'd7680);
        chk("t1_vid_pre_px", 64'(npre), 64'd96);
        chk("t1_vid_guard_px", 64'(ngrd), 64'd24);
        chk("t1_hsync_px", 64'(nhs), 64'd2304);
        chk("t1_hsync_place", 64'(hsbad), 64'd0);
        chk("t1_vsync_px", 64'(nvs), 64'd3200);
        chk("t1_vsync_place", 64'(vsbad), 64'd0);
        chk("t1_frame_starts", 64'(nfs), 64'd2);
        chk("t1_frame_place", 64'(fsbad), 64'd0);
        chk("t1_no_island", 64'(islbad), 64'd0);

        // pkt_req held: two chained packets on every line.
        pkt_req = 1'b1;
        line_xbad = 0;
        run_line(0, 1'b0, -1);
        chk("t2_period_line0", 64'(per_bad(0, 2)), 64'd0);
        chk("t2_ctl_line0", 64'(ctl_bad(0, 2)), 64'd0);
        chk("t2_acks_line0", 64'(ack_cnt()), 64'd2);
        chk("t2_ack_654", 64'(ack_a[654]), 64'd1);
        chk("t2_ack_686", 64'(ack_a[686]), 64'd1);
        chk("t2_active_px", 64'(act_cnt()), 64'd64);
        chk("t2_idx_seq", 64'(idx_bad(2)), 64'd0);
        acc_p = 0; acc_a = 0;
        for (int y = 1; y < VT; y++) begin
            run_line(y, 1'b0, -1);
            acc_p += per_bad(y, 2);
            acc_a += ack_cnt();
        end
        chk("t2_period_frame", 64'(acc_p), 64'd0);
        chk("t2_acks_frame", 64'(acc_a), 64'd22);
        chk("t2_position", 64'(line_xbad), 64'd0);

        // Request dropped after the first ack: a single packet.
        run_line(0, 1'b1, -1);
        chk("t3_period", 64'(per_bad(0, 1)), 64'd0);
        chk("t3_acks", 64'(ack_cnt()), 64'd1);
        chk("t3_ack_654", 64'(ack_a[654]), 64'd1);
        chk("t3_active_px", 64'(act_cnt()), 64'd32);

        // Request raised after DI_START: deferred to the next line.
        run_line(1, 1'b0, 645);
        chk("t4_late_period", 64'(per_bad(1, 0)), 64'd0);
        chk("t4_late_acks", 64'(ack_cnt()), 64'd0);
        run_line(2, 1'b1, -1);
        chk("t4_next_period", 64'(per_bad(2, 1)), 64'd0);
        chk("t4_next_ack_654", 64'(ack_a[654]), 64'd1);
        chk("t4_position", 64'(line_xbad), 64'd0);

        // enable falls mid-packet at x=660 on line 3.
        pkt_req = 1'b1;
        nack = 0;
        for (int x = 0; x <= 660; x++) begin
            @(negedge clk);
            if (pkt_ack === 1'b1) nack++;
        end
        chk("t5_ack_before_abort", 64'(nack), 64'd1);
        chk("t5_pos_at_abort", 64'({counter_y, counter_x}), 64'({10'd3, 10'd660}));
        chk("t5_data_at_abort", 64'(period), 64'd6);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_period_ctrl", 64'(period), 64'd0);
        chk("t5_active_low", 64'(pkt_active), 64'd0);
        chk("t5_counters_zero", 64'({counter_y, counter_x}), 64'd0);
        zbad = 0;
        repeat (40) begin
            @(negedge clk);
            if (all_out() !== 64'd0) zbad++;
        end
        chk("t5_quiet_disabled", 64'(zbad), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("t5_restart_pos", 64'({counter_y, counter_x}), 64'd0);
        chk("t5_restart_fs", 64'(frame_start), 64'd1);
        chk("t5_restart_video", 64'(period), 64'd3);
        pkt_req = 1'b0;

        // Asynchronous reset pulse between clock edges, mid-line.
        repeat (99) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", all_out(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        line_xbad = 0; acc_p = 0; acc_a = 0; acc_fs = 0;
        for (int y = 0; y < VT; y++) begin
            run_line(y, 1'b0, -1);
            acc_p  += per_bad(y, 0);
            acc_a  += ack_cnt();
            acc_fs += fs_cnt();
        end
        chk("t6_frame_position", 64'(line_xbad), 64'd0);
        chk("t6_frame_period", 64'(acc_p), 64'd0);
        chk("t6_frame_acks", 64'(acc_a), 64'd0);
        chk("t6_frame_start", 64'(acc_fs), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
